jjt_bias_engine: RTL and testbench
==================================

Name: jjt_bias_engine

Overview:
- Parametrised successor to the fixed 6x6 Jacobian stage of the inverse-kinematics datapath.
- Computes J*J^T + lambda*I for a ROWS x JOINTS fixed-point Jacobian using one shared external multiplier.
- Uses a sequential multiply-accumulate schedule and computes only the upper triangle, mirroring each result into the lower triangle.
- Sits between the full-Jacobian stage and the damped-least-squares solver. Talks to the shared multiplier bank through dataa/datab/result ports.

Parameters:
ROWS, 6, task-space dimension (rows of J, size of output matrix)
JOINTS, 6, number of joints (columns of J); must be >= 1
DW, 36, signed element width of J, bias and output
FRAC, 16, fractional bits of the fixed-point format
MULT_LAT, 2, fixed latency in cycles of the shared multiplier (>= 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  issue enable; low stalls issue of new products
start  in  1  request a computation; sampled only when busy=0
jacobian_matrix  in  ROWS*JOINTS*DW  J[r][c], row-major, signed
bias  in  DW  lambda added to diagonal entries, signed
busy  out  1  computation in progress
done  out  1  one-cycle pulse when all outputs are written
mult_dataa  out  DW  shared multiplier operand A
mult_datab  out  DW  shared multiplier operand B
mult_result  in  2*DW  signed product, valid MULT_LAT cycles after operands
jjt_bias  out  ROWS*ROWS*DW  output matrix M[i][j], row-major

Behaviour:
- Reset (rst=0, any time including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, mult_dataa=0, mult_datab=0, all jjt_bias entries 0.
  - In-flight products are discarded; the valid shift register is cleared.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 captures jacobian_matrix and bias into internal registers; the source may change afterwards.
  - Clears the accumulator, sets pair index (i=0, j=0) and k=0, then goes to ISSUE. busy=1 from the next cycle.
- ISSUE:
  - When en=1, drives mult_dataa=J[i][k] and mult_datab=J[j][k] and pushes a valid token tagged (i, j, last=(k==JOINTS-1)) into a MULT_LAT-deep shift register.
  - Advances k. On wrap, advances the pair in order (0,0), (0,1) … (0,ROWS-1), (1,1) …, with j >= i.
  - After the last pair/k is issued, goes to DRAIN.
  - en=0: no token is issued and indices hold. The valid pipeline still advances, and returning results are still accumulated.
- Accumulate:
  - acc is 2*DW + clog2(JOINTS)+1 bits, signed. Each returning token adds mult_result.
  - On a last token, the entry value is (acc+product) arithmetically shifted right by FRAC (truncating toward -inf), plus sign-extended bias if i==j.
  - The value is narrowed to DW (see optional feature) and registered into both M[i][j] and M[j][i] one cycle later. acc is then cleared.
- DRAIN: waits until the valid pipeline is empty and the last entry is written. Then pulses done=1 for one cycle, sets busy=0 in that same cycle, and returns to IDLE.
- Latency with en held high: done asserts exactly ROWS*(ROWS+1)/2*JOINTS + MULT_LAT + 2 cycles after the start-sampling edge (6/6/2 gives 130). Each cycle of en=0 during ISSUE adds one cycle.
- start while busy=1, including in the done cycle, is ignored.
- jjt_bias holds its previous values until individually overwritten. Entries update progressively during a run, and the full matrix is consistent only at done.
- mult_dataa/mult_datab hold their last values when not issuing.

Optional Feature:
- JJT_SAT_EN defined:
  - Narrowing to DW saturates to [-2^(DW-1), 2^(DW-1)-1].
  - Adds a sticky output port sat_flag (1 bit), set when any entry clipped during a run, cleared on start accept and on reset.
- JJT_SAT_EN undefined: narrowing keeps the low DW bits (two's-complement wrap) and the sat_flag port is absent.

Test Plan:
- Identity: ROWS=JOINTS=6, FRAC=16, J[r][r]=0x10000, other J entries 0, bias=0x0199A -> diagonal 0x1199A, off-diagonal 0; done at cycle 130.
- All-ones: every J entry 0x10000, bias=0 -> all 36 entries 0x60000.
- Symmetry and sign: J row0=[0x10000,0x20000,0,0,0,0], row1=[-0x10000,0x10000,0,0,0,0], others 0, bias 0 -> M[0][1]=M[1][0]=0x10000, M[0][0]=0x50000, M[1][1]=0x20000.
- Saturation (JJT_SAT_EN): row0 all 0x7_FFFF_FFFF, row1 all -0x7_FFFF_FFFF -> M[0][0]=0x7_FFFF_FFFF, M[0][1]=0x8_0000_0000, sat_flag=1. Without the macro -> low 36 bits of the exact value.
- Stall and ignore: toggle en low for 10 cycles mid-ISSUE and pulse start during busy -> identity-case results unchanged, done at cycle 140, exactly one done pulse.
- Reset mid-run: drop rst at cycle 50 -> all outputs 0 immediately. A subsequent start runs to full, correct completion.

Source files
------------

// File: rtl/jjt_bias_engine.sv
// jjt_bias_engine: computes M = J*J^T + lambda*I for a ROWS x JOINTS signed
// fixed-point Jacobian through one shared external multiplier. Only the upper
// triangle is multiplied; each finished entry is written to M[i][j] and M[j][i].
// Optional build macro: JJT_SAT_EN. When defined, narrowing to DW saturates
// and a sticky sat_flag output is added. When undefined, narrowing wraps.
module jjt_bias_engine #(
    parameter int ROWS     = 6,
    parameter int JOINTS   = 6,
    parameter int DW       = 36,
    parameter int FRAC     = 16,
    parameter int MULT_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic [ROWS*JOINTS*DW-1:0]  jacobian_matrix,
    input  logic [DW-1:0]              bias,
    output logic                       busy,
    output logic                       done,
    output logic [DW-1:0]              mult_dataa,
    output logic [DW-1:0]              mult_datab,
    input  logic [2*DW-1:0]            mult_result,
    output logic [ROWS*ROWS*DW-1:0]    jjt_bias
`ifdef JJT_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam int AW = 2*DW + $clog2(JOINTS) + 1;          // accumulator width
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;      // row index width
    localparam int KW = (JOINTS > 1) ? $clog2(JOINTS) : 1;  // joint index width
    localparam int NE = ROWS * ROWS;
    localparam int NJ = ROWS * JOINTS;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int JW = (NJ > 1) ? $clog2(NJ) : 1;
    // Stage 0 travels with the registered operands; the product for a token
    // is on mult_result while that token sits in the final stage MULT_LAT.
    localparam int PD = MULT_LAT + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_q;

    logic signed [DW-1:0] jm_q [NJ];
    logic signed [DW-1:0] bias_q;
    logic signed [DW-1:0] m_q [NE];
    logic [IW-1:0]        i_q;
    logic [IW-1:0]        j_q;
    logic [KW-1:0]        k_q;

    logic [PD-1:0]        vld_q;
    logic [PD-1:0]        tl_q;
    logic [IW-1:0]        ti_q [PD];
    logic [IW-1:0]        tj_q [PD];

    logic signed [AW-1:0] acc_q;
    logic                 wr_en_q;
    logic [IW-1:0]        wr_i_q;
    logic [IW-1:0]        wr_j_q;
    logic signed [DW-1:0] wr_val_q;

    logic                 last_k_d;
    logic [JW-1:0]        ia_d;
    logic [JW-1:0]        ib_d;
    logic [EW-1:0]        wa_d;
    logic [EW-1:0]        wb_d;
    logic signed [AW-1:0] sum_d;
    logic signed [DW-1:0] nar_d;
    logic                 diag_d;
`ifdef JJT_SAT_EN
    localparam int VW = AW + 1;  // shifted sum plus bias with one guard bit
    logic signed [AW-1:0] sh_d;
    logic signed [VW-1:0] val_d;
    logic                 clip_d;
`endif

    // Operand addresses, write addresses and the value of a finishing entry
    always_comb begin
        last_k_d = (k_q == KW'(JOINTS - 1));
        ia_d     = JW'(32'(i_q) * JOINTS + 32'(k_q));
        ib_d     = JW'(32'(j_q) * JOINTS + 32'(k_q));
        wa_d     = EW'(32'(wr_i_q) * ROWS + 32'(wr_j_q));
        wb_d     = EW'(32'(wr_j_q) * ROWS + 32'(wr_i_q));
        diag_d   = (ti_q[PD-1] == tj_q[PD-1]);
        sum_d    = acc_q + {{(AW-2*DW){mult_result[2*DW-1]}}, mult_result};
`ifdef JJT_SAT_EN
        sh_d   = sum_d >>> FRAC;
        val_d  = {sh_d[AW-1], sh_d}
               + (diag_d ? {{(VW-DW){bias_q[DW-1]}}, bias_q} : '0);
        // Anything outside DW bits shows up as non-uniform upper bits.
        clip_d = (val_d[VW-1:DW-1] != {(VW-DW+1){val_d[VW-1]}});
        if (clip_d)
            nar_d = val_d[VW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            nar_d = val_d[DW-1:0];
`else
        nar_d = DW'(sum_d >>> FRAC) + (diag_d ? bias_q : '0);
`endif
    end

    // Control FSM, operand issue, token pipeline, accumulation and matrix writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mult_dataa <= '0;
            mult_datab <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            vld_q      <= '0;
            tl_q       <= '0;
            acc_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_i_q     <= '0;
            wr_j_q     <= '0;
            wr_val_q   <= '0;
            bias_q     <= '0;
            for (int n = 0; n < PD; n++) begin
                ti_q[n] <= '0;
                tj_q[n] <= '0;
            end
            for (int n = 0; n < NJ; n++) jm_q[n] <= '0;
            for (int n = 0; n < NE; n++) m_q[n] <= '0;
`ifdef JJT_SAT_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            wr_en_q <= 1'b0;

            // Tokens advance every cycle, independent of en.
            vld_q <= {vld_q[PD-2:0], 1'b0};
            tl_q  <= {tl_q[PD-2:0], 1'b0};
            for (int n = 1; n < PD; n++) begin
                ti_q[n] <= ti_q[n-1];
                tj_q[n] <= tj_q[n-1];
            end

            // Returning product: accumulate, or finish the entry on its last term.
            if (vld_q[PD-1]) begin
                if (tl_q[PD-1]) begin
                    acc_q    <= '0;
                    wr_en_q  <= 1'b1;
                    wr_i_q   <= ti_q[PD-1];
                    wr_j_q   <= tj_q[PD-1];
                    wr_val_q <= nar_d;
`ifdef JJT_SAT_EN
                    if (clip_d) sat_flag <= 1'b1;
`endif
                end else begin
                    acc_q <= sum_d;
                end
            end

            // Finished entries land in both mirror positions.
            if (wr_en_q) begin
                m_q[wa_d] <= wr_val_q;
                m_q[wb_d] <= wr_val_q;
            end

            case (state_q)
                IDLE: begin
                    // A start during the done cycle is ignored.
                    if (start && !done) begin
                        for (int n = 0; n < NJ; n++) jm_q[n] <= jacobian_matrix[n*DW +: DW];
                        bias_q  <= bias;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        state_q <= ISSUE;
`ifdef JJT_SAT_EN
                        sat_flag <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    if (en) begin
                        mult_dataa <= jm_q[ia_d];
                        mult_datab <= jm_q[ib_d];
                        vld_q[0]   <= 1'b1;
                        tl_q[0]    <= last_k_d;
                        ti_q[0]    <= i_q;
                        tj_q[0]    <= j_q;
                        if (last_k_d) begin
                            k_q <= '0;
                            if (j_q == IW'(ROWS - 1)) begin
                                if (i_q == IW'(ROWS - 1)) begin
                                    state_q <= DRAIN;
                                end else begin
                                    i_q <= i_q + 1'b1;
                                    j_q <= i_q + 1'b1;
                                end
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Empty pipeline means the final entry is being written now.
                    if (!(|vld_q)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Flatten the matrix registers onto the row-major output bus
    generate
        for (genvar gi = 0; gi < NE; gi++) begin : g_out
            assign jjt_bias[gi*DW +: DW] = m_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_jjt_bias_engine.sv
// Testbench for jjt_bias_engine: models the shared multiplier, drives directed
// and randomized Jacobians and compares against a whole-matrix reference.
module tb_jjt_bias_engine;

    localparam int ROWS     = 6;
    localparam int JOINTS   = 6;
    localparam int DW       = 36;
    localparam int FRAC     = 16;
    localparam int MULT_LAT = 2;
    localparam int NPROD    = ROWS * (ROWS + 1) / 2 * JOINTS;
    localparam logic signed [127:0] VMAX = (128'sd1 <<< (DW - 1)) - 128'sd1;
    localparam logic signed [127:0] VMIN = -(128'sd1 <<< (DW - 1));

    logic                       clk;
    logic                       rst;
    logic                       en;
    logic                       start;
    logic [ROWS*JOINTS*DW-1:0]  jacobian_matrix;
    logic [DW-1:0]              bias;
    logic                       busy;
    logic                       done;
    logic [DW-1:0]              mult_dataa;
    logic [DW-1:0]              mult_datab;
    logic [2*DW-1:0]            mult_result;
    logic [ROWS*ROWS*DW-1:0]    jjt_bias;
`ifdef JJT_SAT_EN
    logic                       sat_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] jm_v [ROWS][JOINTS];
    logic [DW-1:0] bias_v;
    logic [DW-1:0] exp_m [ROWS*ROWS];
    bit            exp_sat;

    jjt_bias_engine #(
        .ROWS(ROWS), .JOINTS(JOINTS), .DW(DW), .FRAC(FRAC), .MULT_LAT(MULT_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .start(start),
        .jacobian_matrix(jacobian_matrix),
        .bias(bias),
        .busy(busy),
        .done(done),
        .mult_dataa(mult_dataa),
        .mult_datab(mult_datab),
        .mult_result(mult_result),
        .jjt_bias(jjt_bias)
`ifdef JJT_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: product appears MULT_LAT cycles after the operands.
    logic signed [2*DW-1:0] mpipe [MULT_LAT];
    logic signed [2*DW-1:0] pa;
    logic signed [2*DW-1:0] pb;
    assign pa = {{DW{mult_dataa[DW-1]}}, mult_dataa};
    assign pb = {{DW{mult_datab[DW-1]}}, mult_datab};
    always @(posedge clk) begin
        mpipe[0] <= pa * pb;
        for (int n = 1; n < MULT_LAT; n++) mpipe[n] <= mpipe[n-1];
    end
    assign mult_result = mpipe[MULT_LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [127:0] sx(input logic [DW-1:0] x);
        return {{(128-DW){x[DW-1]}}, x};
    endfunction

    function automatic logic [DW-1:0] rnd_el();
        logic [63:0] t;
        logic signed [DW-1:0] e;
        t = {$urandom(), $urandom()};
        e = t[DW-1:0];
        return e >>> $urandom_range(0, 24);
    endfunction

    // Reference: full matrix product from the captured J, then bias and narrowing.
    task automatic build_model();
        logic signed [127:0] s;
        logic signed [127:0] v;
        exp_sat = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < ROWS; j++) begin
                s = '0;
                for (int k = 0; k < JOINTS; k++) s = s + sx(jm_v[i][k]) * sx(jm_v[j][k]);
                v = (s >>> FRAC) + ((i == j) ? sx(bias_v) : 128'sd0);
`ifdef JJT_SAT_EN
                if (v > VMAX) begin
                    v = VMAX;
                    exp_sat = 1'b1;
                end else if (v < VMIN) begin
                    v = VMIN;
                    exp_sat = 1'b1;
                end
`endif
                exp_m[i*ROWS+j] = v[DW-1:0];
            end
        end
    endtask

    task automatic clear_j();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < JOINTS; c++) jm_v[r][c] = '0;
        bias_v = '0;
    endtask

    task automatic scramble_inputs();
        for (int b = 0; b < ROWS*JOINTS; b++) jacobian_matrix[b*DW +: DW] = rnd_el();
        bias = rnd_el();
    endtask

    // One computation: start, per-cycle en, ignored starts, done timing and results.
    task automatic run_op(input string name, input bit rand_en, input int stall_at,
                          input int stall_len, input int abort_at);
        int  cyc;
        int  issued;
        int  exp_done;
        int  done_cnt;
        bit  post_done;
        bit  finished;
        @(negedge clk);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < JOINTS; c++) jacobian_matrix[(r*JOINTS+c)*DW +: DW] = jm_v[r][c];
        bias  = bias_v;
        start = 1'b1;
        en    = 1'b1;
        build_model();
        @(posedge clk);
        cyc = 0; issued = 0; exp_done = -1; done_cnt = 0; post_done = 0; finished = 0;
        while (!finished && cyc < 2000) begin
            @(negedge clk);
            start = (cyc == 5 || cyc == 60);
            if (cyc == 0 || cyc == 5 || cyc == 60) scramble_inputs();
            if (cyc == 1) check_eq({name, " busy"}, 64'(busy), 64'd1);
            if (cyc == abort_at) begin
                start = 1'b0;
                rst   = 1'b0;
                #1;
                check_eq({name, " rst busy"}, 64'(busy), 64'd0);
                check_eq({name, " rst done"}, 64'(done), 64'd0);
                check_eq({name, " rst dataa"}, 64'(mult_dataa), 64'd0);
                check_eq({name, " rst datab"}, 64'(mult_datab), 64'd0);
                check_eq({name, " rst matrix_zero"}, 64'(jjt_bias == '0), 64'd1);
`ifdef JJT_SAT_EN
                check_eq({name, " rst sat"}, 64'(sat_flag), 64'd0);
`endif
                @(negedge clk);
                rst = 1'b1;
                $display("run %s aborted by reset at cycle %0d", name, cyc);
                return;
            end
            if (post_done) begin
                check_eq({name, " busy after done"}, 64'(busy), 64'd0);
                check_eq({name, " done width"}, 64'(done), 64'd0);
                check_eq({name, " done pulses"}, 64'(done_cnt), 64'd1);
                start = 1'b0;
                finished = 1'b1;
            end else if (done) begin
                done_cnt++;
                check_eq({name, " done cycle"}, 64'(cyc), 64'(exp_done));
                check_eq({name, " busy at done"}, 64'(busy), 64'd0);
                for (int e = 0; e < ROWS*ROWS; e++)
                    check_eq($sformatf("%s M%0d%0d", name, e / ROWS, e % ROWS),
                             64'(jjt_bias[e*DW +: DW]), 64'(exp_m[e]));
`ifdef JJT_SAT_EN
                check_eq({name, " sat"}, 64'(sat_flag), 64'(exp_sat));
`endif
                $display("run %s done_cycle=%0d expected=%0d", name, cyc, exp_done);
                start = 1'b1;
                post_done = 1'b1;
            end
            if (rand_en) en = ($urandom_range(0, 3) != 0);
            else         en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (en && issued < NPROD) begin
                issued++;
                if (issued == NPROD) exp_done = cyc + 1 + MULT_LAT + 2;
            end
            cyc++;
        end
        if (!finished) check_eq({name, " timeout"}, 64'd0, 64'd1);
        start = 1'b0;
    endtask

    task automatic set_identity();
        clear_j();
        for (int r = 0; r < ROWS; r++) jm_v[r][r] = 36'h0_0001_0000;
        bias_v = 36'h0_0000_199A;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; start = 1'b0;
        jacobian_matrix = '0; bias = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);
        check_eq("reset dataa", 64'(mult_dataa), 64'd0);
        check_eq("reset matrix_zero", 64'(jjt_bias == '0), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        set_identity();
        run_op("identity", 1'b0, 10000, 0, -1);

        clear_j();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < JOINTS; c++) jm_v[r][c] = 36'h0_0001_0000;
        run_op("allones", 1'b0, 10000, 0, -1);

        clear_j();
        jm_v[0][0] = 36'h0_0001_0000; jm_v[0][1] = 36'h0_0002_0000;
        jm_v[1][0] = 36'hF_FFFF_0000; jm_v[1][1] = 36'h0_0001_0000;
        run_op("symsign", 1'b0, 10000, 0, -1);

        clear_j();
        for (int c = 0; c < JOINTS; c++) begin
            jm_v[0][c] = 36'h7_FFFF_FFFF;
            jm_v[1][c] = 36'h8_0000_0001;
        end
        run_op("saturate", 1'b0, 10000, 0, -1);

        set_identity();
        run_op("stall", 1'b0, 20, 10, -1);

        set_identity();
        run_op("abort", 1'b0, 10000, 0, 50);
        run_op("after_abort", 1'b0, 10000, 0, -1);

        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < JOINTS; c++) jm_v[r][c] = rnd_el();
            bias_v = rnd_el();
            run_op($sformatf("random%0d", t), 1'b1, 0, 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
